// File: rtl/ft64_regwb_sched_if.sv
// Result-producer / register-file write bundle for the writeback scheduler.
// The scheduler takes the slave side; producers and the register file the master side.
interface ft64_regwb_sched_if #(
    parameter int WID   = 64,
    parameter int RBIT  = 11,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]     in_v;
    logic [3:0]     in_rdy;
    logic [RBIT:0]  in_a0, in_a1, in_a2, in_a3;
    logic [WID-1:0] in_d0, in_d1, in_d2, in_d3;
    logic           hold;
    logic           wr0, wr1, wr2;
    logic [RBIT:0]  wa0, wa1, wa2;
    logic [WID-1:0] i0, i1, i2;
    logic [CW-1:0]  count;
    logic           busy;

    modport master (
        output in_v, in_a0, in_a1, in_a2, in_a3, in_d0, in_d1, in_d2, in_d3, hold,
        input  in_rdy, wr0, wr1, wr2, wa0, wa1, wa2, i0, i1, i2, count, busy
    );

    modport slave (
        input  in_v, in_a0, in_a1, in_a2, in_a3, in_d0, in_d1, in_d2, in_d3, hold,
        output in_rdy, wr0, wr1, wr2, wa0, wa1, wa2, i0, i1, i2, count, busy
    );
endinterface

// File: rtl/ft64_regwb_sched.sv
// Writeback scheduler: queues up to four results per cycle and drains up to three
// per cycle, oldest first, onto the register-file write ports.
module ft64_regwb_sched #(
    parameter int WID   = 64,
    parameter int RBIT  = 11,
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst_n,
    ft64_regwb_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;

    logic [RBIT:0]  mem_a [DEPTH];
    logic [WID-1:0] mem_d [DEPTH];

    ptr_t          head, tail;
    logic [CW-1:0] count_q;
    logic [CW-1:0] free;
    logic [3:0]    rdy;
    logic [3:0]    take;
    logic [2:0]    stored;
    logic [1:0]    n;
    ptr_t          slot [4];
    logic [RBIT:0]  a_in [4];
    logic [WID-1:0] d_in [4];

    always_comb begin
        a_in[0] = bus.in_a0;
        a_in[1] = bus.in_a1;
        a_in[2] = bus.in_a2;
        a_in[3] = bus.in_a3;
        d_in[0] = bus.in_d0;
        d_in[1] = bus.in_d1;
        d_in[2] = bus.in_d2;
        d_in[3] = bus.in_d3;
    end

    // Accepted address-0 results are dropped, so later producers slide down into their slot.
    always_comb begin
        free   = CW'(DEPTH) - count_q;
        rdy    = '0;
        take   = '0;
        stored = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            rdy[k]  = rst_n && (free >= CW'(k + 1));
            take[k] = bus.in_v[k] && rdy[k] && (a_in[k] != '0);
            slot[k] = tail + ptr_t'(stored);
            if (take[k])
                stored = stored + 3'd1;
        end
    end

    always_comb begin
        if (bus.hold)
            n = 2'd0;
        else if (count_q >= CW'(3))
            n = 2'd3;
        else
            n = count_q[1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + ptr_t'(n);
            tail    <= tail + ptr_t'(stored);
            count_q <= count_q + CW'(stored) - CW'(n);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (take[k]) begin
                mem_a[slot[k]] <= a_in[k];
                mem_d[slot[k]] <= d_in[k];
            end
        end
    end

    assign bus.in_rdy = rdy;
    assign bus.count  = count_q;
    assign bus.busy   = (count_q != '0);
    assign bus.wr0    = (n != 2'd0);
    assign bus.wr1    = (n >= 2'd2);
    assign bus.wr2    = (n == 2'd3);
    assign bus.wa0    = mem_a[head];
    assign bus.wa1    = mem_a[head + ptr_t'(1)];
    assign bus.wa2    = mem_a[head + ptr_t'(2)];
    assign bus.i0     = mem_d[head];
    assign bus.i1     = mem_d[head + ptr_t'(1)];
    assign bus.i2     = mem_d[head + ptr_t'(2)];
endmodule

// File: tb/tb_ft64_regwb_sched.sv
// Bench for ft64_regwb_sched: directed vector table plus random traffic checked
// against a queue-based model of the writeback FIFO.
module tb_ft64_regwb_sched;
    localparam int WID   = 64;
    localparam int RBIT  = 11;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ft64_regwb_sched_if #(.WID(WID), .RBIT(RBIT), .DEPTH(DEPTH)) bus ();

    ft64_regwb_sched #(.WID(WID), .RBIT(RBIT), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [RBIT:0]  a;
        logic [WID-1:0] d;
    } ent_t;

    typedef struct packed {
        logic           r;
        logic           h;
        logic [3:0]     v;
        logic [RBIT:0]  a0, a1, a2, a3;
        logic [WID-1:0] db;
        logic [3:0]     e_rdy;
        logic [2:0]     e_wr;
        logic [RBIT:0]  e_wa0;
        logic [WID-1:0] e_i0;
        logic [3:0]     e_cnt;
    } vec_t;

    ent_t q[$];
    vec_t tbl[$];
    logic [RBIT:0]  cur_a [4];
    logic [WID-1:0] cur_d [4];
    int unsigned pass_cnt = 0;
    int unsigned total = 0;

    function automatic vec_t mk(input logic r, input logic h, input logic [3:0] v,
                                input logic [RBIT:0] a0, input logic [RBIT:0] a1,
                                input logic [RBIT:0] a2, input logic [RBIT:0] a3,
                                input logic [WID-1:0] db, input logic [3:0] e_rdy,
                                input logic [2:0] e_wr, input logic [RBIT:0] e_wa0,
                                input logic [WID-1:0] e_i0, input logic [3:0] e_cnt);
        vec_t t;
        t.r = r; t.h = h; t.v = v;
        t.a0 = a0; t.a1 = a1; t.a2 = a2; t.a3 = a3; t.db = db;
        t.e_rdy = e_rdy; t.e_wr = e_wr; t.e_wa0 = e_wa0; t.e_i0 = e_i0; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Producer k carries data db+k.
    task automatic drive(input logic r, input logic h, input logic [3:0] v,
                         input logic [RBIT:0] a0, input logic [RBIT:0] a1,
                         input logic [RBIT:0] a2, input logic [RBIT:0] a3,
                         input logic [WID-1:0] db);
        @(negedge clk);
        rst_n = r;
        bus.hold = h;
        bus.in_v = v;
        cur_a[0] = a0; cur_a[1] = a1; cur_a[2] = a2; cur_a[3] = a3;
        for (int k = 0; k < 4; k++) cur_d[k] = db + WID'(k);
        bus.in_a0 = cur_a[0]; bus.in_a1 = cur_a[1]; bus.in_a2 = cur_a[2]; bus.in_a3 = cur_a[3];
        bus.in_d0 = cur_d[0]; bus.in_d1 = cur_d[1]; bus.in_d2 = cur_d[2]; bus.in_d3 = cur_d[3];
        #1;
    endtask

    // Compares pre-edge outputs with the model, then applies the coming edge to the model.
    task automatic model_step(input bit do_chk);
        int unsigned fr, n;
        logic [3:0] er;
        logic [2:0] ew;
        logic [RBIT:0]  wa [3];
        logic [WID-1:0] wd [3];
        fr = DEPTH - q.size();
        er = '0;
        for (int k = 0; k < 4; k++) er[k] = rst_n && (fr >= k + 1);
        n = bus.hold ? 0 : ((q.size() < 3) ? q.size() : 3);
        ew = '0;
        for (int j = 0; j < 3; j++) ew[j] = (j < n);
        wa[0] = bus.wa0; wa[1] = bus.wa1; wa[2] = bus.wa2;
        wd[0] = bus.i0;  wd[1] = bus.i1;  wd[2] = bus.i2;
        if (do_chk) begin
            chk("m_rdy", 64'(bus.in_rdy), 64'(er));
            chk("m_count", 64'(bus.count), 64'(q.size()));
            chk("m_busy", 64'(bus.busy), 64'(q.size() != 0));
            chk("m_wr", 64'({bus.wr2, bus.wr1, bus.wr0}), 64'(ew));
            for (int j = 0; j < 3; j++) begin
                if (j < n) begin
                    chk($sformatf("m_wa%0d", j), 64'(wa[j]), 64'(q[j].a));
                    chk($sformatf("m_i%0d", j), wd[j], q[j].d);
                end
            end
        end
        if (!rst_n) begin
            q.delete();
        end else begin
            repeat (n) void'(q.pop_front());
            for (int k = 0; k < 4; k++)
                if (bus.in_v[k] && er[k] && cur_a[k] != '0)
                    q.push_back('{a: cur_a[k], d: cur_d[k]});
        end
    endtask

    initial begin
        logic [3:0] rdyh [8];
        rdyh = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

        // single producer, then four-wide burst, same-address pair, address-0 drop
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b000, 0, 0,      0));
        tbl.push_back(mk(1, 0, 4'b0001, 5, 0, 0, 0, 'hAA,   4'b1111, 3'b000, 0, 0,      0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b001, 5, 'hAA,   1));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b000, 0, 0,      0));
        tbl.push_back(mk(1, 0, 4'b1111, 1, 2, 3, 4, 'h10,   4'b1111, 3'b000, 0, 0,      0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b111, 1, 'h10,   4));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b001, 4, 'h13,   1));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b000, 0, 0,      0));
        tbl.push_back(mk(1, 0, 4'b0011, 7, 7, 0, 0, 1,      4'b1111, 3'b000, 0, 0,      0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b011, 7, 1,      2));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b000, 0, 0,      0));
        tbl.push_back(mk(1, 0, 4'b0100, 0, 0, 0, 0, 'h55,   4'b1111, 3'b000, 0, 0,      0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b000, 0, 0,      0));
        // hold while filling across the pointer wrap, full rejects, then 3/3/2 drain
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 4'b0001, RBIT'(i + 1), 0, 0, 0, 100 + i, rdyh[i], 3'b000, 0, 0, 4'(i)));
        tbl.push_back(mk(1, 1, 4'b1111, 9, 9, 9, 9, 'h999,  4'b0000, 3'b000, 0, 0,      8));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b0000, 3'b111, 1, 100,    8));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b0111, 3'b111, 4, 103,    5));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b011, 7, 106,    2));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b000, 0, 0,      0));
        // reset while holding five entries and a same-cycle burst
        tbl.push_back(mk(1, 1, 4'b1111, 21, 22, 23, 24, 'h200, 4'b1111, 3'b000, 0, 0,   0));
        tbl.push_back(mk(1, 1, 4'b0001, 25, 0, 0, 0, 'h300, 4'b1111, 3'b000, 0, 0,      4));
        tbl.push_back(mk(0, 0, 4'b1111, 31, 32, 33, 34, 'h400, 4'b0000, 3'b111, 21, 'h200, 5));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b000, 0, 0,      0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0,      4'b1111, 3'b000, 0, 0,      0));

        drive(0, 0, 4'b1111, 1, 2, 3, 4, 0);
        chk("reset_rdy", 64'(bus.in_rdy), 64'(4'b0000));
        model_step(0);
        drive(0, 0, 4'b0000, 0, 0, 0, 0, 0);
        model_step(1);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            t = tbl[i];
            drive(t.r, t.h, t.v, t.a0, t.a1, t.a2, t.a3, t.db);
            chk($sformatf("row%0d_rdy", i), 64'(bus.in_rdy), 64'(t.e_rdy));
            chk($sformatf("row%0d_wr", i), 64'({bus.wr2, bus.wr1, bus.wr0}), 64'(t.e_wr));
            chk($sformatf("row%0d_count", i), 64'(bus.count), 64'(t.e_cnt));
            if (t.e_wr[0]) begin
                chk($sformatf("row%0d_wa0", i), 64'(bus.wa0), 64'(t.e_wa0));
                chk($sformatf("row%0d_i0", i), bus.i0, t.e_i0);
            end
            model_step(1);
        end

        for (int c = 0; c < 800; c++) begin
            logic [RBIT:0] ra [4];
            for (int k = 0; k < 4; k++)
                ra[k] = ($urandom_range(0, 3) == 0) ? '0 : RBIT'($urandom);
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, 4'($urandom),
                  ra[0], ra[1], ra[2], ra[3], {32'($urandom), 32'($urandom)});
            model_step(1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/ft64_regwb_sched.md
FT64_REGWB_SCHED -- requirements
Module: ft64_regwb_sched

Interface
REQ-001 The block SHALL have parameter WID, default 64, register data width.
REQ-002 The block SHALL have parameter RBIT, default 11, register address MSB (address is RBIT+1 bits).
REQ-003 The block SHALL have parameter DEPTH, default 8, queue entries; power of two, minimum 4.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have ports in_v[3:0]  input  4  per-producer result valid.
REQ-007 The block SHALL have ports in_rdy[3:0]  output  4  per-producer accept.
REQ-008 The block SHALL have ports in_a0..in_a3  input  RBIT+1 each  destination register.
REQ-009 The block SHALL have ports in_d0..in_d3  input  WID each  result data.
REQ-010 The block SHALL have port hold  input  1  suppresses all register-file writes this cycle.
REQ-011 The block SHALL have ports wr0, wr1, wr2  output  1 each  register-file write enables.
REQ-012 The block SHALL have ports wa0, wa1, wa2  output  RBIT+1 each  write addresses.
REQ-013 The block SHALL have ports i0, i1, i2  output  WID each  write data.
REQ-014 The block SHALL have port count  output  clog2(DEPTH)+1  occupied entries.
REQ-015 The block SHALL have port busy  output  1  count != 0.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH {addr,data} entries with registered head pointer, tail pointer and count; pointers wrap modulo DEPTH.
REQ-017 Define free = DEPTH - count, taken from the registered count only (same-cycle drains never raise free); in_rdy[k] SHALL be (free >= k+1) && rst_n, independent of in_v.
REQ-018 A transfer on producer k SHALL occur when in_v[k] && in_rdy[k] are high at the clock edge.
REQ-019 Transferred entries SHALL be enqueued in ascending producer index within a cycle, so index 0 is oldest.
REQ-020 A transfer with address 0 SHALL be accepted but not stored, and SHALL not advance the tail.
REQ-021 Drain count n SHALL be min(count, 3) when hold is low, and 0 when hold is high.
REQ-022 wrJ SHALL be (J < n); waJ/iJ SHALL be the entry at head+J (mod DEPTH), driven directly from storage registers with no combinational path from in_*.
REQ-023 When wrJ is low, waJ and iJ SHALL still show head+J contents; consumers ignore them.
REQ-024 At each edge, head SHALL advance by n, tail SHALL advance by the number stored, and count SHALL become count + stored - n.
REQ-025 Ordering: oldest drained entry SHALL be on port 0 and youngest on port 2, so the file's port-2-wins rule keeps the youngest value on same-address collisions.
REQ-026 Latency: an entry accepted at edge T SHALL be visible on a write port from cycle T+1 onward, provided hold is low and fewer than 3 older entries exist.
REQ-027 Simultaneous enqueue and drain in one cycle SHALL both take effect; count never exceeds DEPTH and never underflows.
REQ-028 Full (count==DEPTH): in_rdy SHALL be 4'b0000; draining continues.
REQ-029 Empty: wr0..wr2 SHALL be 0 and busy SHALL be 0.

Reset
REQ-030 While rst_n is low at an edge, head, tail and count SHALL become 0 and all entries SHALL be discarded, including mid-drain entries and same-cycle transfers.
REQ-031 In the cycle after reset, wr0..wr2 SHALL be 0, count 0, busy 0 and in_rdy 4'b1111.
REQ-032 While rst_n is low, in_rdy SHALL be 4'b0000.
REQ-033 Entry storage SHALL need no reset; outputs are gated by count.

Verification
REQ-034 Scenario: after reset, in_v=4'b0001, in_a0=5, in_d0=0xAA for 1 cycle -> next cycle wr0=1, wa0=5, i0=0xAA, wr1=wr2=0; following cycle count=0.
REQ-035 Scenario: one cycle with in_v=4'b1111 to addresses 1,2,3,4 -> next cycle wr0..wr2 carry addresses 1,2,3 and count=4; cycle after that wr0 carries address 4 and count=1.
REQ-036 Scenario: hold=1 while 8 single entries are pushed -> count=8, in_rdy=0000; at count=6, in_rdy=0011; drop hold -> 3/3/2 drained in FIFO order across the pointer wrap.
REQ-037 Scenario: in_v=4'b0011 with in_a0=in_a1=7, in_d0=1, in_d1=2 -> wr0/wa0=7/1 and wr1/wa1=7/2 in the same cycle.
REQ-038 Scenario: in_a2=0 with in_v=4'b0100 -> in_rdy[2]=1 and the transfer is accepted, but count stays 0 and no write is issued.
REQ-039 Scenario: rst_n low for 1 cycle while count=5 and in_v=1111 -> count=0, no wr, and none of those inputs later appear on a write port.
